// File: rtl/vram_filler_pkg.sv
// Shared constants, FSM state encoding and the test pattern for the VRAM fill-and-verify engine.
package vram_filler_pkg;
  localparam int VRAM_LEN   = 6912;
  localparam int BITMAP_LEN = 6144;
  localparam int OFS_W      = 13;
  localparam int TMR_W      = 8;

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_GAP, RD_SETUP, RD_WAIT, RD_CHECK, DONE
  } state_e;

  // Bitmap bytes carry the low address byte; attribute bytes keep bits 7:6 clear.
  function automatic logic [7:0] pattern(input logic [OFS_W-1:0] ofs);
    if (ofs < OFS_W'(BITMAP_LEN)) return ofs[7:0];
    else                          return {2'b00, ofs[5:0]};
  endfunction
endpackage

// File: rtl/vram_filler_timer.sv
// Loadable down-counter; zero_o marks the final cycle of a timed FSM state.
module vram_filler_timer
  import vram_filler_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/vram_filler.sv
// Writes the 6912-byte screen pattern through SRAM port 2, reads it all back and counts mismatches.
module vram_filler #(
  parameter int WR_LOW  = 4,
  parameter int WR_GAP  = 2,
  parameter int RD_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [17:0] a2,
  output logic        we2_n,
  output logic        oe2_n,
  output logic [7:0]  din2,
  input  logic [7:0]  dout2,
  output logic        busy,
  output logic        done,
  output logic [12:0] err_count
);
  import vram_filler_pkg::*;

  // Gap state runs one cycle past WR_GAP: that last cycle advances the offset.
  localparam logic [TMR_W-1:0] LOW_LD   = TMR_W'(WR_LOW - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(WR_GAP);
  localparam logic [TMR_W-1:0] RDW_LD   = TMR_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(VRAM_LEN - 1);

  state_e             state_q, state_d;
  logic [OFS_W-1:0]   ofs_q, ofs_d;
  logic [OFS_W-1:0]   err_q, err_d;
  logic               tmr_ld, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;

  vram_filler_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_ld),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    ofs_d   = ofs_q;
    err_d   = err_q;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = WR_SETUP;
        ofs_d   = '0;
        err_d   = '0;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        tmr_ld  = 1'b1;
        tmr_val = LOW_LD;
      end
      WR_PULSE: if (tmr_zero) begin
        state_d = vram_filler_pkg::WR_GAP;
        tmr_ld  = 1'b1;
        tmr_val = GAP_LD;
      end
      vram_filler_pkg::WR_GAP: if (tmr_zero) begin
        if (ofs_q == LAST_OFS) begin
          ofs_d   = '0;
          state_d = RD_SETUP;
        end else begin
          ofs_d   = ofs_q + OFS_W'(1);
          state_d = WR_SETUP;
        end
      end
      RD_SETUP: begin
        if (RD_WAIT == 0) state_d = RD_CHECK;
        else begin
          state_d = vram_filler_pkg::RD_WAIT;
          tmr_ld  = 1'b1;
          tmr_val = RDW_LD;
        end
      end
      vram_filler_pkg::RD_WAIT: if (tmr_zero) state_d = RD_CHECK;
      RD_CHECK: begin
        if (dout2 != pattern(ofs_q)) err_d = err_q + OFS_W'(1);
        if (ofs_q == LAST_OFS) state_d = DONE;
        else begin
          ofs_d   = ofs_q + OFS_W'(1);
          state_d = RD_SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ofs_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ofs_q   <= ofs_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from the state register so reset releases them without waiting for a clock.
  assign a2        = {5'b00000, ofs_q};
  assign din2      = pattern(ofs_q);
  assign we2_n     = (state_q != WR_PULSE);
  assign oe2_n     = !(state_q == vram_filler_pkg::RD_WAIT || state_q == RD_CHECK);
  assign busy      = !(state_q == IDLE || state_q == DONE);
  assign done      = (state_q == DONE);
  assign err_count = err_q;
endmodule

// File: tb/tb_vram_filler.sv
// Randomised scoreboard bench: fast-timed DUT for full passes, default-timed DUT for strobe timing.
module tb_vram_filler;
  localparam int WL = 1, WG = 0, RW = 0;
  localparam int N  = 6912 * (2 + WL + WG) + 6912 * (2 + RW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, fault_en;
  logic [17:0] a2;
  logic we2_n, oe2_n, busy, done;
  logic [7:0] din2, dout2;
  logic [12:0] err_count;

  logic b_rst, b_start;
  logic [17:0] b_a2;
  logic b_we2_n, b_oe2_n, b_busy, b_done;
  logic [7:0] b_din2;
  logic [12:0] b_err_count;

  vram_filler #(.WR_LOW(WL), .WR_GAP(WG), .RD_WAIT(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .a2(a2), .we2_n(we2_n), .oe2_n(oe2_n),
    .din2(din2), .dout2(dout2), .busy(busy), .done(done), .err_count(err_count));

  vram_filler dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .a2(b_a2), .we2_n(b_we2_n), .oe2_n(b_oe2_n),
    .din2(b_din2), .dout2(8'h00), .busy(b_busy), .done(b_done), .err_count(b_err_count));

  // Ideal SRAM with an optional stuck-at-1 on bit 0 of address 0x00010.
  logic [7:0] mem [0:8191];
  assign dout2 = mem[a2[12:0]] | ((fault_en && a2 == 18'h00010) ? 8'h01 : 8'h00);

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pat(input int o);
    return (o < 6144) ? o % 256 : o % 64;
  endfunction

  function automatic int exp_errs(input bit f);
    int n = 0;
    for (int o = 0; o < 6912; o++)
      if ((pat(o) | ((f && o == 16) ? 1 : 0)) != pat(o)) n++;
    return n;
  endfunction

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int err; int cyc0; } pass_t;
  wr_t   exp_wr[$];
  pass_t exp_pass[$];

  // Monitor for the main DUT: consumes expected writes and pass results.
  wr_t   mw;
  pass_t mp;
  logic  pwe = 1'b1, pdone = 1'b0;
  int    wlen = 0, ovl_cnt = 0, rng_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      pwe = 1'b1; pdone = 1'b0; wlen = 0;
    end else begin
      if (!we2_n && !oe2_n) ovl_cnt++;
      if (a2 > 18'h01AFF) rng_cnt++;
      if (!we2_n) begin
        mem[a2[12:0]] = din2;
        wlen++;
      end
      if (pwe && !we2_n) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          mw = exp_wr.pop_front();
          chk("wr_addr", a2, mw.addr);
          chk("wr_data", din2, mw.data);
        end
      end
      if (!pwe && we2_n) begin
        chk("we_width", wlen, WL);
        wlen = 0;
      end
      if (done && !pdone) begin
        if (exp_pass.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mp = exp_pass.pop_front();
          chk("err_count", err_count, mp.err);
          chk("pass_len", cyc - mp.cyc0, N);
          chk("wr_left", exp_wr.size(), 0);
        end
      end
      pwe = we2_n; pdone = done;
    end
  end

  // Monitor for the default-timed DUT: strobe widths, periods and write order.
  logic b_pwe = 1'b1, b_poe = 1'b1;
  int b_wlen = 0, b_olen = 0, b_wr = 0, b_rd = 0, b_lastw = -1, b_lasto = -1;
  int b_ovl = 0, b_rng = 0;
  always @(negedge clk) begin
    if (!b_rst) begin
      if (!b_we2_n && !b_oe2_n) b_ovl++;
      if (b_a2 > 18'h01AFF) b_rng++;
      if (!b_we2_n) b_wlen++;
      if (!b_oe2_n) b_olen++;
      if (b_pwe && !b_we2_n) begin
        chk("b_wr_addr", b_a2, b_wr);
        if (b_lastw >= 0) chk("b_wr_period", cyc - b_lastw, 8);
        b_lastw = cyc; b_wr++;
      end
      if (!b_pwe && b_we2_n) begin chk("b_we_width", b_wlen, 4); b_wlen = 0; end
      if (b_poe && !b_oe2_n) begin
        if (b_lasto >= 0) chk("b_rd_period", cyc - b_lasto, 6);
        b_lasto = cyc; b_rd++;
      end
      if (!b_poe && b_oe2_n) begin chk("b_oe_width", b_olen, 5); b_olen = 0; end
      b_pwe = b_we2_n; b_poe = b_oe2_n;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic new_pass(input bit f);
    pulse_start();
    exp_pass.push_back('{exp_errs(f), cyc});
    for (int o = 0; o < 6912; o++) exp_wr.push_back('{o, pat(o)});
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_err_clr", err_count, 0);
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < N + 200 && !ok; i++) begin
      @(negedge clk); ok = done;
    end
    chk(nm, ok, 1);
    @(negedge clk);
  endtask

  task automatic wait_write(input int ofs, input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (!we2_n && a2 == 18'(ofs));
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    int act, k;
    rst = 1'b0; start = 1'b0; fault_en = 1'b0; b_rst = 1'b0; b_start = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    #1 rst = 1'b1; b_rst = 1'b1;
    #1;
    chk("rst_a2", a2, 0);        chk("rst_din2", din2, 0);
    chk("rst_we", we2_n, 1);     chk("rst_oe", oe2_n, 1);
    chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
    chk("rst_err", err_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; b_rst = 1'b0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;

    // Abort mid-write at offset 3000.
    new_pass(1'b0);
    wait_write(3000, 20000, "reach_wr_3000");
    #1 rst = 1'b1;
    #1;
    chk("abort_we", we2_n, 1);  chk("abort_oe", oe2_n, 1);
    chk("abort_busy", busy, 0); chk("abort_a2", a2, 0);
    exp_wr.delete(); exp_pass.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (!we2_n || !oe2_n || busy || done) act++;
    end
    chk("post_abort_idle", act, 0);

    // Faulty pass with start re-pulsed while busy.
    fault_en = 1'b1;
    new_pass(1'b1);
    wait_write(10, 1000, "reach_wr_10");
    pulse_start();
    k = $urandom_range(1, 3);
    repeat (k) begin
      repeat ($urandom_range(50, 5000)) @(negedge clk);
      pulse_start();
    end
    wait_done("done_pass_a");
    chk("pass_a_err", err_count, 1);

    // Clean pass started from DONE.
    fault_en = 1'b0;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    chk("done_hold", done, 1);   chk("err_hold", err_count, 1);
    chk("done_busy", busy, 0);   chk("done_we", we2_n, 1);
    chk("done_oe", oe2_n, 1);
    new_pass(1'b0);
    wait_done("done_pass_b");
    chk("pass_b_err", err_count, 0);
    chk("mem_100", mem[100], 8'h64);
    chk("mem_6200", mem[6200], 8'h38);

    chk("sb_empty", exp_pass.size(), 0);
    chk("bus_overlap", ovl_cnt, 0);
    chk("a2_range", rng_cnt, 0);
    chk("b_overlap", b_ovl, 0);
    chk("b_a2_range", b_rng, 0);
    chk("b_wr_count", b_wr, 6912);
    chk("b_rd_seen", (b_rd > 0), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
